// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_det_ctrl_if : frame handshake and per-frame result bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface seq_det_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              frm_valid;
  logic [DATA_W-1:0] frm_data;
  logic              frm_ready;
  logic              res_valid;
  logic [CNT_W-1:0]  res_cnt;
  logic              res_ovf;

  modport master (
    output frm_valid, frm_data,
    input  frm_ready, res_valid, res_cnt, res_ovf
  );

  modport slave (
    input  frm_valid, frm_data,
    output frm_ready, res_valid, res_cnt, res_ovf
  );
endinterface
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_det_ctrl : serialises frames MSB-first and counts aligned detector hits
// Rev 1.0
// ---------------------------------------------------------------------------
module seq_det_ctrl #(
  parameter int DATA_W  = 8,
  parameter int DET_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_det_ctrl_if.slave bus,
  output logic         ser_en_o,
  output logic         ser_bit_o,
  input  logic         det_hit_i,
  output logic         busy_o
);

  localparam int K_W = $clog2(DATA_W + DET_LAT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [K_W-1:0]   K_SHIFT_END = K_W'(DATA_W - 1);
  localparam logic [K_W-1:0]   K_DRAIN_END = K_W'(DATA_W + DET_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [1:0]        state_q,     state_d;
  logic [DATA_W-1:0] shift_q,     shift_d;
  logic [K_W-1:0]    k_q,         k_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              ovf_q,       ovf_d;
  logic              ser_en_q,    ser_en_d;
  logic              ser_bit_q,   ser_bit_d;
  logic              res_valid_q, res_valid_d;
  logic [CNT_W-1:0]  res_cnt_q,   res_cnt_d;
  logic              res_ovf_q,   res_ovf_d;

  logic w_in_win;
  logic w_sample;

  // Window opens DET_LAT cycles after the first bit so each sample lines up with one frame bit
  generate
    if (DET_LAT == 0) begin : g_win_nolat
      assign w_in_win = 1'b1;
    end else begin : g_win_lat
      assign w_in_win = (k_q >= K_W'(DET_LAT));
    end
  endgenerate

  assign w_sample = det_hit_i && w_in_win &&
                    ((state_q == S_SHIFT) || (state_q == S_DRAIN));

  always_comb begin
    logic to_report;
    to_report   = 1'b0;
    state_d     = state_q;
    shift_d     = shift_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    ser_en_d    = 1'b0;
    ser_bit_d   = 1'b0;
    res_valid_d = 1'b0;
    res_cnt_d   = res_cnt_q;
    res_ovf_d   = res_ovf_q;

    if (w_sample) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.frm_valid) begin
          state_d   = S_SHIFT;
          shift_d   = {bus.frm_data[DATA_W-2:0], 1'b0};
          k_d       = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          ser_en_d  = 1'b1;
          ser_bit_d = bus.frm_data[DATA_W-1];
        end
      end
      S_SHIFT: begin
        k_d = k_q + 1'b1;
        if (k_q == K_SHIFT_END) begin
          if (DET_LAT > 0) begin
            state_d = S_DRAIN;
          end else begin
            state_d   = S_REPORT;
            to_report = 1'b1;
          end
        end else begin
          ser_en_d  = 1'b1;
          ser_bit_d = shift_q[DATA_W-1];
          shift_d   = {shift_q[DATA_W-2:0], 1'b0};
        end
      end
      S_DRAIN: begin
        k_d = k_q + 1'b1;
        if (k_q == K_DRAIN_END) begin
          state_d   = S_REPORT;
          to_report = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result captures the count including the final window sample
    if (to_report) begin
      res_valid_d = 1'b1;
      res_cnt_d   = cnt_d;
      res_ovf_d   = ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      ser_en_q    <= 1'b0;
      ser_bit_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      ser_en_q    <= ser_en_d;
      ser_bit_q   <= ser_bit_d;
      res_valid_q <= res_valid_d;
      res_cnt_q   <= res_cnt_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign bus.frm_ready = (state_q == S_IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_cnt   = res_cnt_q;
  assign bus.res_ovf   = res_ovf_q;
  assign ser_en_o      = ser_en_q;
  assign ser_bit_o     = ser_bit_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_det_ctrl : three parameterisations of seq_det_ctrl with detector models
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_seq_det_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // unit 0: defaults, unit 1: CNT_W=3, unit 2: DET_LAT=0
  seq_det_ctrl_if #(.DATA_W(8), .CNT_W(4)) a_if ();
  seq_det_ctrl_if #(.DATA_W(8), .CNT_W(3)) b_if ();
  seq_det_ctrl_if #(.DATA_W(8), .CNT_W(4)) c_if ();

  logic a_en, a_bit, a_hit, a_busy, a_dq, force_a;
  logic b_en, b_bit, b_hit, b_busy, b_dq;
  logic c_en, c_bit, c_hit, c_busy;

  always @(posedge clk) a_dq <= a_en & a_bit;
  always @(posedge clk) b_dq <= b_en & b_bit;
  assign a_hit = a_dq | (force_a & (!a_busy | a_if.res_valid));
  assign b_hit = b_dq;
  assign c_hit = c_en & c_bit;

  seq_det_ctrl #(.DATA_W(8), .DET_LAT(1), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if), .ser_en_o(a_en), .ser_bit_o(a_bit),
    .det_hit_i(a_hit), .busy_o(a_busy));
  seq_det_ctrl #(.DATA_W(8), .DET_LAT(1), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if), .ser_en_o(b_en), .ser_bit_o(b_bit),
    .det_hit_i(b_hit), .busy_o(b_busy));
  seq_det_ctrl #(.DATA_W(8), .DET_LAT(0), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if), .ser_en_o(c_en), .ser_bit_o(c_bit),
    .det_hit_i(c_hit), .busy_o(c_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int u, input logic v, input logic [7:0] d);
    case (u)
      0:       begin a_if.frm_valid = v; a_if.frm_data = d; end
      1:       begin b_if.frm_valid = v; b_if.frm_data = d; end
      default: begin c_if.frm_valid = v; c_if.frm_data = d; end
    endcase
  endtask

  function automatic logic g_rdy(input int u);
    logic r;
    case (u) 0: r = a_if.frm_ready; 1: r = b_if.frm_ready; default: r = c_if.frm_ready; endcase
    return r;
  endfunction
  function automatic logic g_rv(input int u);
    logic r;
    case (u) 0: r = a_if.res_valid; 1: r = b_if.res_valid; default: r = c_if.res_valid; endcase
    return r;
  endfunction
  function automatic logic g_en(input int u);
    logic r;
    case (u) 0: r = a_en; 1: r = b_en; default: r = c_en; endcase
    return r;
  endfunction
  function automatic logic g_bit(input int u);
    logic r;
    case (u) 0: r = a_bit; 1: r = b_bit; default: r = c_bit; endcase
    return r;
  endfunction
  function automatic logic [3:0] g_cnt(input int u);
    logic [3:0] r;
    case (u) 0: r = a_if.res_cnt; 1: r = {1'b0, b_if.res_cnt}; default: r = c_if.res_cnt; endcase
    return r;
  endfunction
  function automatic logic g_ovf(input int u);
    logic r;
    case (u) 0: r = a_if.res_ovf; 1: r = b_if.res_ovf; default: r = c_if.res_ovf; endcase
    return r;
  endfunction

  // Reference: with the delay-matched detector every '1' frame bit is one hit
  function automatic int exp_cnt(input logic [7:0] d, input int cw);
    int pc, mx;
    pc = $countones(d);
    mx = (1 << cw) - 1;
    return (pc > mx) ? mx : pc;
  endfunction
  function automatic logic exp_ovf(input logic [7:0] d, input int cw);
    return $countones(d) > ((1 << cw) - 1);
  endfunction

  // Sends one frame; lat counts cycles from the accept cycle to the strobe (-1 on timeout)
  task automatic run_frame(input int u, input logic [7:0] data, output int lat,
                           output logic [3:0] cnt, output logic ovf,
                           output logic [7:0] bits, output int en_n);
    int w;
    w = 0; bits = '0; en_n = 0;
    set_in(u, 1'b1, data);
    while (!g_rdy(u) && w < 40) begin tick(); w++; end
    tick();
    set_in(u, 1'b0, 8'($urandom));
    lat = 1;
    while (!g_rv(u) && lat < 40) begin
      if (g_en(u)) begin bits = {bits[6:0], g_bit(u)}; en_n++; end
      tick();
      lat++;
    end
    if (!g_rv(u)) lat = -1;
    cnt = g_cnt(u);
    ovf = g_ovf(u);
  endtask

  task automatic test_reset();
    n_chk++; if (a_if.frm_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", a_if.frm_ready); else n_pass++;
    n_chk++; if ({a_en, a_bit} !== 2'b00) $display("FAIL reset_ser got=%b exp=00", {a_en, a_bit}); else n_pass++;
    n_chk++; if (a_if.res_valid !== 1'b0) $display("FAIL reset_rv got=%b exp=0", a_if.res_valid); else n_pass++;
    n_chk++; if ({a_if.res_cnt, a_if.res_ovf} !== 5'd0) $display("FAIL reset_res got=%h exp=0", {a_if.res_cnt, a_if.res_ovf}); else n_pass++;
    n_chk++; if ({a_busy, b_busy, c_busy} !== 3'b000) $display("FAIL reset_busy got=%b exp=000", {a_busy, b_busy, c_busy}); else n_pass++;
  endtask

  task automatic test_basic();
    int lat, en_n; logic [3:0] cnt; logic ovf; logic [7:0] bits;
    run_frame(0, 8'hB6, lat, cnt, ovf, bits, en_n);
    n_chk++; if (bits !== 8'hB6) $display("FAIL basic_bits got=%h exp=b6", bits); else n_pass++;
    n_chk++; if (en_n != 8) $display("FAIL basic_en_cycles got=%0d exp=8", en_n); else n_pass++;
    n_chk++; if (lat != 10) $display("FAIL basic_latency got=%0d exp=10", lat); else n_pass++;
    n_chk++; if (cnt !== 4'd5 || ovf !== 1'b0) $display("FAIL basic_res got=%0d/%b exp=5/0", cnt, ovf); else n_pass++;
    tick();
    n_chk++; if (a_if.res_valid !== 1'b0 || a_if.res_cnt !== 4'd5) $display("FAIL basic_hold got=%b/%0d exp=0/5", a_if.res_valid, a_if.res_cnt); else n_pass++;
  endtask

  task automatic test_ignore_outside();
    int lat, en_n, rv_n; logic [3:0] cnt; logic ovf; logic [7:0] bits;
    force_a = 1'b1;
    rv_n = 0;
    repeat (5) begin tick(); if (a_if.res_valid) rv_n++; end
    n_chk++; if (rv_n != 0) $display("FAIL idle_no_strobe got=%0d exp=0", rv_n); else n_pass++;
    run_frame(0, 8'h00, lat, cnt, ovf, bits, en_n);
    n_chk++; if (cnt !== 4'd0 || ovf !== 1'b0) $display("FAIL ignore_res got=%0d/%b exp=0/0", cnt, ovf); else n_pass++;
    tick();
    force_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc_t[2]; int acc_n, low_n, r_n, cyc; logic [3:0] res[2];
    acc_n = 0; low_n = 0; r_n = 0; cyc = 0;
    acc_t[0] = 0; acc_t[1] = 0; res[0] = '0; res[1] = '0;
    set_in(0, 1'b1, 8'hFF);
    while (r_n < 2 && cyc < 60) begin
      if (acc_n == 1 && !a_if.frm_ready) low_n++;
      if (a_if.frm_ready && acc_n < 2) begin acc_t[acc_n] = cyc; acc_n++; end
      if (a_if.res_valid) begin res[r_n] = a_if.res_cnt; r_n++; end
      tick();
      cyc++;
      if (acc_n == 1) a_if.frm_data = 8'h01;
      if (acc_n == 2) a_if.frm_valid = 1'b0;
    end
    n_chk++; if (r_n != 2) $display("FAIL b2b_results got=%0d exp=2", r_n); else n_pass++;
    n_chk++; if (acc_t[1] - acc_t[0] != 11) $display("FAIL b2b_spacing got=%0d exp=11", acc_t[1] - acc_t[0]); else n_pass++;
    n_chk++; if (low_n != 10) $display("FAIL b2b_ready_low got=%0d exp=10", low_n); else n_pass++;
    n_chk++; if (res[0] !== 4'd8 || res[1] !== 4'd1) $display("FAIL b2b_cnts got=%0d,%0d exp=8,1", res[0], res[1]); else n_pass++;
  endtask

  task automatic test_saturate();
    int lat, en_n; logic [3:0] cnt; logic ovf; logic [7:0] bits;
    run_frame(1, 8'hFF, lat, cnt, ovf, bits, en_n);
    n_chk++; if (cnt !== 4'd7 || ovf !== 1'b1) $display("FAIL sat_res got=%0d/%b exp=7/1", cnt, ovf); else n_pass++;
    run_frame(1, 8'h03, lat, cnt, ovf, bits, en_n);
    n_chk++; if (cnt !== 4'd2 || ovf !== 1'b0) $display("FAIL sat_next got=%0d/%b exp=2/0", cnt, ovf); else n_pass++;
  endtask

  task automatic test_zero_lat();
    int lat, en_n; logic [3:0] cnt; logic ovf; logic [7:0] bits;
    run_frame(2, 8'hA5, lat, cnt, ovf, bits, en_n);
    n_chk++; if (cnt !== 4'd4 || ovf !== 1'b0) $display("FAIL zlat_res got=%0d/%b exp=4/0", cnt, ovf); else n_pass++;
    n_chk++; if (lat != 9) $display("FAIL zlat_latency got=%0d exp=9", lat); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, en_n, rv_n, w; logic [3:0] cnt; logic ovf; logic [7:0] bits;
    w = 0;
    set_in(0, 1'b1, 8'hFF);
    while (!a_if.frm_ready && w < 40) begin tick(); w++; end
    tick();
    set_in(0, 1'b0, 8'h00);
    repeat (3) tick();
    n_chk++; if (a_en !== 1'b1 || a_busy !== 1'b1) $display("FAIL rmid_in_shift got=%b%b exp=11", a_en, a_busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({a_if.frm_ready, a_busy, a_en, a_bit} !== 4'b1000) $display("FAIL rmid_ctrl got=%b exp=1000", {a_if.frm_ready, a_busy, a_en, a_bit}); else n_pass++;
    n_chk++; if ({a_if.res_valid, a_if.res_cnt, a_if.res_ovf} !== 6'd0) $display("FAIL rmid_res got=%h exp=0", {a_if.res_valid, a_if.res_cnt, a_if.res_ovf}); else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    rv_n = 0;
    repeat (15) begin tick(); if (a_if.res_valid) rv_n++; end
    n_chk++; if (rv_n != 0) $display("FAIL rmid_no_strobe got=%0d exp=0", rv_n); else n_pass++;
    run_frame(0, 8'h0F, lat, cnt, ovf, bits, en_n);
    n_chk++; if (cnt !== 4'd4 || ovf !== 1'b0) $display("FAIL rmid_after got=%0d/%b exp=4/0", cnt, ovf); else n_pass++;
  endtask

  task automatic test_random();
    int lat, en_n, cw, el; logic [3:0] cnt; logic ovf; logic [7:0] bits, d;
    for (int u = 0; u < 3; u++) begin
      cw = (u == 1) ? 3 : 4;
      el = (u == 2) ? 9 : 10;
      for (int i = 0; i < 8; i++) begin
        d = 8'($urandom);
        if (i == 0) d = 8'hFF;
        repeat ($urandom_range(0, 3)) tick();
        run_frame(u, d, lat, cnt, ovf, bits, en_n);
        n_chk++;
        if (cnt !== 4'(exp_cnt(d, cw)) || ovf !== exp_ovf(d, cw) || lat != el || bits !== d)
          $display("FAIL rand_u%0d_%0d data=%h got cnt=%0d ovf=%b lat=%0d bits=%h exp cnt=%0d ovf=%b lat=%0d",
                   u, i, d, cnt, ovf, lat, bits, exp_cnt(d, cw), exp_ovf(d, cw), el);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    force_a = 1'b0;
    for (int u = 0; u < 3; u++) set_in(u, 1'b0, 8'h00);
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_ignore_outside();
    test_back_to_back();
    test_saturate();
    test_zero_lat();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Frame sequencer for the serial sequence detector. Accepts parallel frames over a valid/ready handshake and serialises each frame MSB-first into the detector's seq_in, one bit per clock. Counts detector hits (seq_out) inside a latency-aligned window and reports one hit count per frame. Sits between a parallel source (CPU/FIFO) and the seq_det instance.

Parameters:
DATA_W, 8, frame width in bits (2..64)
DET_LAT, 1, cycles from a bit on ser_bit to its hit on det_hit (0..7)
CNT_W, 4, hit-count width (1..7); count saturates

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
frm_valid  input  1  source has a frame
frm_data  input  DATA_W  frame, bit DATA_W-1 sent first
frm_ready  output  1  controller can accept a frame
ser_en  output  1  ser_bit carries a valid frame bit
ser_bit  output  1  serial bit to detector seq_in
det_hit  input  1  detector seq_out
res_valid  output  1  one-cycle result strobe
res_cnt  output  CNT_W  hits counted in the frame just finished
res_ovf  output  1  count saturated during that frame
busy  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; frm_ready=1, ser_en=0, ser_bit=0, res_valid=0, res_cnt=0, res_ovf=0, busy=0; shift reg, cycle counter, hit counter cleared.
- All outputs registered except frm_ready and busy, which are decoded from state.
- FSM states: IDLE, SHIFT, DRAIN, REPORT.
- IDLE: frm_ready=1. On frm_valid&&frm_ready: latch frm_data, clear cycle index k and hit count, go to SHIFT. No accept in any other state; frm_data is ignored unless accepted.
- SHIFT: DATA_W cycles, k=0..DATA_W-1. ser_en=1, ser_bit=latched bit DATA_W-1-k, visible in the same cycle the state is SHIFT. After k=DATA_W-1: go to DRAIN if DET_LAT>0, else REPORT.
- DRAIN: DET_LAT cycles, k=DATA_W..DATA_W+DET_LAT-1. ser_en=0, ser_bit=0. Then go to REPORT.
- Hit window: det_hit sampled only when DET_LAT <= k < DATA_W+DET_LAT, i.e. exactly DATA_W samples, each aligned to one frame bit. det_hit outside the window, including in IDLE and REPORT, is ignored.
- Count: +1 per sampled hit. Saturates at 2^CNT_W-1. A hit arriving while the count is saturated sets the internal ovf flag.
- REPORT: 1 cycle. res_valid=1; res_cnt and res_ovf hold the final count and flag. Next state is IDLE.
- res_cnt and res_ovf hold their values until the next REPORT. res_valid is low in all other cycles.
- Accept-to-strobe latency: DATA_W+DET_LAT+1 cycles. Minimum accept-to-accept spacing with frm_valid held high: DATA_W+DET_LAT+2 cycles.
- frm_valid deasserting mid-frame has no effect. A frame, once accepted, always completes.
- rst_n low mid-frame: immediate return to reset values. Partial frame is discarded and no res_valid is produced.
- Detector state is not cleared between frames; any cross-frame history belongs to the detector.

Test Plan:
- Defaults; bench detector model det_hit = ser_en&ser_bit delayed 1 cycle. Send frm_data=8'hB6 -> ser_bit sequence 1,0,1,1,0,1,1,0; res_valid exactly 10 cycles after accept; res_cnt=5, res_ovf=0.
- frm_valid held high, frames 8'hFF then 8'h01 -> accepts 11 cycles apart; frm_ready low from the cycle after accept until back in IDLE; res_cnt=8 then 1.
- CNT_W=3, frame 8'hFF with the same model -> res_cnt=7, res_ovf=1. Next frame 8'h03 -> res_cnt=2, res_ovf=0.
- det_hit forced to 1 during IDLE and REPORT; frame 8'h00 with the model -> res_cnt=0.
- DET_LAT=0, det_hit = ser_en&ser_bit combinationally; frame 8'hA5 -> res_cnt=4; res_valid 9 cycles after accept.
- Assert rst_n low at SHIFT k=3 -> all outputs at reset values immediately; no res_valid. After release, frame 8'h0F -> res_cnt=4.
